note_period_meter: RTL and testbench

Listen-mode front end of the tuner. Measures the period of an incoming square-wave tone (comparator-squared microphone signal) by counting system clocks between rising edges. It rejects glitches, requires a run of consistent periods before declaring lock, and reports the locked period in the same clock-cycle units the tone generator uses for playback. It sits between the audio input pin and the note-matching logic, opposite the tone generator.

---
 rtl/note_period_meter.sv | 176 +++++++++++++++++
 tb/tb_note_period_meter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_period_meter.sv
// Tone period meter: synchronizes a squared audio input, times rising edges
// in clk cycles, rejects glitches and reports a locked period once stable.
module note_period_meter #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int MIN_PERIOD  = 1000,
    parameter int MAX_PERIOD  = 1_000_000,
    parameter int TOL         = 64,
    parameter int MATCH_COUNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        listen,
    input  logic        audioIn,
    output logic [19:0] period,
    output logic        periodValid,
    output logic        locked,
    output logic        noSignal
);

    // Elaborates to nothing; marks parameter sets the datapath cannot represent.
    if (CLK_FREQ <= 0 || MAX_PERIOD >= (1 << 20) || MATCH_COUNT < 2 || MATCH_COUNT > 7)
    begin : g_bad_config
    end

    localparam logic [19:0] MIN_P   = 20'(MIN_PERIOD);
    localparam logic [19:0] MAX_P   = 20'(MAX_PERIOD);
    localparam logic [19:0] TOL_W   = 20'(TOL);
    localparam logic [2:0]  MATCH_C = 3'(MATCH_COUNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_LOCKED
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        sync3_q, sync3_d;
    logic [19:0] cnt_q, cnt_d;
    logic [19:0] prev_q, prev_d;
    logic [19:0] period_q, period_d;
    logic [2:0]  run_q, run_d;
    logic        period_valid_q, period_valid_d;
    logic        locked_q, locked_d;
    logic        no_signal_q, no_signal_d;

    logic        strobe;
    logic        accept;
    logic        consistent;
    logic        timeout;
    logic [19:0] cnt_inc;
    logic [19:0] diff;
    logic [2:0]  run_next;

    assign strobe     = sync2_q & ~sync3_q;
    assign accept     = strobe && (cnt_q >= MIN_P) && (cnt_q <= MAX_P);
    assign timeout    = (cnt_q == MAX_P) && !strobe;
    assign cnt_inc    = (cnt_q == MAX_P) ? cnt_q : cnt_q + 20'd1;
    assign diff       = (cnt_q > prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);
    assign consistent = (diff <= TOL_W);
    assign run_next   = (run_q == 3'd0 || !consistent) ? 3'd1 :
                        (run_q == MATCH_C)             ? run_q : run_q + 3'd1;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        sync1_d        = audioIn;
        sync2_d        = sync1_q;
        sync3_d        = sync2_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        prev_d         = prev_q;
        run_d          = run_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        no_signal_d    = no_signal_q;

        if (!listen) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            prev_d      = '0;
            run_d       = '0;
            period_d    = '0;
            locked_d    = 1'b0;
            no_signal_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ARM;

                S_ARM: begin
                    // The arming edge only starts the timer; its interval is not a sample.
                    if (strobe) begin
                        cnt_d       = 20'd1;
                        no_signal_d = 1'b0;
                        run_d       = '0;
                        state_d     = S_MEASURE;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_q == MAX_P) no_signal_d = 1'b1;
                    end
                end

                S_MEASURE, S_LOCKED: begin
                    if (accept) begin
                        cnt_d  = 20'd1;
                        prev_d = cnt_q;
                        if (state_q == S_MEASURE) begin
                            run_d = run_next;
                            if (run_next == MATCH_C) begin
                                period_d       = cnt_q;
                                period_valid_d = 1'b1;
                                locked_d       = 1'b1;
                                state_d        = S_LOCKED;
                            end
                        end else if (consistent) begin
                            period_d       = cnt_q;
                            period_valid_d = 1'b1;
                        end else begin
                            locked_d = 1'b0;
                            run_d    = 3'd1;
                            state_d  = S_MEASURE;
                        end
                    end else if (timeout) begin
                        no_signal_d = 1'b1;
                        locked_d    = 1'b0;
                        period_d    = '0;
                        run_d       = '0;
                        cnt_d       = '0;
                        state_d     = S_ARM;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            sync3_q        <= 1'b0;
            cnt_q          <= '0;
            prev_q         <= '0;
            run_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            no_signal_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sync3_q        <= sync3_d;
            cnt_q          <= cnt_d;
            prev_q         <= prev_d;
            run_q          <= run_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            no_signal_q    <= no_signal_d;
        end
    end

    assign period      = period_q;
    assign periodValid = period_valid_q;
    assign locked      = locked_q;
    assign noSignal    = no_signal_q;

endmodule

// File: tb/tb_note_period_meter.sv
// Bench for note_period_meter: sample-history model compared every cycle,
// plus hand-computed expectations at scenario boundaries (scaled-down periods).
module tb_note_period_meter;

    localparam int MIN_P   = 20;
    localparam int MAX_P   = 1000;
    localparam int TOL_P   = 4;
    localparam int MATCH_P = 4;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        listen   = 1'b0;
    logic        audio_in = 1'b0;
    logic [19:0] period;
    logic        period_valid;
    logic        locked;
    logic        no_signal;

    int checks   = 0;
    int errors   = 0;
    int pv_count = 0;

    always #5 clk = ~clk;

    note_period_meter #(
        .CLK_FREQ   (50_000_000),
        .MIN_PERIOD (MIN_P),
        .MAX_PERIOD (MAX_P),
        .TOL        (TOL_P),
        .MATCH_COUNT(MATCH_P)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .listen     (listen),
        .audioIn    (audio_in),
        .period     (period),
        .periodValid(period_valid),
        .locked     (locked),
        .noSignal   (no_signal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Listening modes: 0 idle, 1 waiting for the arming edge, 2 tracking samples.
    int          m_mode = 0;
    int          m_elapsed = 0;
    bit          m_h0 = 0, m_h1 = 0, m_h2 = 0;
    bit          m_strobe;
    int          m_samples[$];
    logic [19:0] m_period = '0;
    bit          m_pv = 0, m_locked = 0, m_nosig = 0;

    // Length of the consistent run ending at the newest accepted sample.
    function automatic int trailing_run();
        int r = 1;
        for (int i = m_samples.size() - 1; i > 0; i--) begin
            int d = m_samples[i] - m_samples[i-1];
            if (d < 0) d = -d;
            if (d <= TOL_P) r++;
            else break;
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_elapsed = 0;
            m_h0 = 0; m_h1 = 0; m_h2 = 0;
            m_samples.delete();
            m_period = '0; m_pv = 0; m_locked = 0; m_nosig = 0;
        end else begin
            // Input delayed two cycles, then a rising-edge test.
            m_strobe = m_h1 && !m_h2;
            m_h2 = m_h1; m_h1 = m_h0; m_h0 = audio_in;
            m_pv = 0;
            if (!listen) begin
                m_mode = 0; m_elapsed = 0; m_samples.delete();
                m_period = '0; m_locked = 0; m_nosig = 0;
            end else if (m_mode == 0) begin
                m_mode = 1; m_elapsed = 0;
            end else if (m_mode == 1) begin
                if (m_strobe) begin
                    m_mode = 2; m_elapsed = 1; m_nosig = 0; m_samples.delete();
                end else if (m_elapsed == MAX_P) begin
                    m_nosig = 1;
                end else begin
                    m_elapsed++;
                end
            end else begin
                if (m_strobe && m_elapsed >= MIN_P && m_elapsed <= MAX_P) begin
                    m_samples.push_back(m_elapsed);
                    if (m_samples.size() > MATCH_P) void'(m_samples.pop_front());
                    if (trailing_run() >= MATCH_P) begin
                        m_locked = 1; m_period = 20'(m_elapsed); m_pv = 1;
                    end else begin
                        m_locked = 0;
                    end
                    m_elapsed = 1;
                end else if (m_elapsed >= MAX_P) begin
                    m_nosig = 1; m_locked = 0; m_period = '0;
                    m_samples.delete(); m_mode = 1; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("outputs{period,pv,locked,nosig}",
              {period, period_valid, locked, no_signal},
              {m_period, m_pv, m_locked, m_nosig});
        if (period_valid) pv_count++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tone(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            audio_in = 1'b1;
            tick(p / 2);
            audio_in = 1'b0;
            tick(p - p / 2);
        end
    endtask

    int pv_before;

    initial begin
        // Reset held while the input toggles.
        for (int i = 0; i < 8; i++) begin
            audio_in = ~audio_in;
            tick(3);
        end
        audio_in = 1'b0;
        #1;
        check("reset_hold", {period, period_valid, locked, no_signal}, 32'd0);
        tick(1);
        reset = 1'b1;
        tick(10);
        #1;
        check("idle_listen0", {period, period_valid, locked, no_signal}, 32'd0);

        // Clean tone: lock on the fifth rising edge.
        listen = 1'b1;
        tick(2);
        tone(227, 4);
        #1;
        check("tone_pre_lock", locked, 1'b0);
        check("tone_pre_lock_pv", pv_count, 0);
        tone(227, 1);
        #1;
        check("tone_lock", locked, 1'b1);
        check("tone_period", period, 20'd227);
        check("tone_pv_once", pv_count, 1);
        tone(227, 3);
        #1;
        check("tone_pv_each", pv_count, 4);

        // Move to 200: one more 227 sample, then relock on four 200 samples.
        tone(200, 5);
        #1;
        check("relock_200", {locked, period}, {1'b1, 20'd200});

        // Short low notch early in the high phase gives a sub-MIN edge.
        pv_before = pv_count;
        audio_in = 1'b1; tick(5);
        audio_in = 1'b0; tick(3);
        audio_in = 1'b1; tick(92);
        audio_in = 1'b0; tick(100);
        #1;
        check("glitch_pv", pv_count, pv_before + 1);
        check("glitch_lock", {locked, period}, {1'b1, 20'd200});
        tone(200, 1);
        #1;
        check("after_glitch_pv", pv_count, pv_before + 2);
        check("after_glitch_period", period, 20'd200);

        // Difference of exactly TOL stays locked; TOL+1 drops lock.
        tone(204, 1);
        tone(200, 1);
        #1;
        check("tol_equal", {locked, period}, {1'b1, 20'd204});
        tone(205, 1);
        tone(200, 1);
        #1;
        check("tol_over", {locked, period}, {1'b0, 20'd200});
        tone(100, 4);
        #1;
        check("relock_100_pending", locked, 1'b0);
        tone(100, 1);
        #1;
        check("relock_100", {locked, period}, {1'b1, 20'd100});

        // Shortest accepted period.
        tone(MIN_P, 6);
        #1;
        check("min_period", {locked, period}, {1'b1, 20'd20});

        // Longest period: strobe lands on cnt==MAX, no timeout.
        tone(MAX_P, 6);
        #1;
        check("max_period", {locked, period, no_signal}, {1'b1, 20'd1000, 1'b0});

        // Timeout with the input held low.
        tone(200, 5);
        #1;
        check("pre_timeout_lock", {locked, period}, {1'b1, 20'd200});
        tick(700);
        #1;
        check("pre_timeout_nosig", {no_signal, locked}, {1'b0, 1'b1});
        tick(200);
        #1;
        check("timeout", {no_signal, locked, period}, {1'b1, 1'b0, 20'd0});
        tone(200, 1);
        #1;
        check("resume_clear", {no_signal, locked}, {1'b0, 1'b0});
        tone(200, 4);
        #1;
        check("resume_lock", {locked, period}, {1'b1, 20'd200});

        // listen drop clears outputs after one edge.
        tick(1);
        listen = 1'b0;
        tick(1);
        #1;
        check("listen_drop", {period, period_valid, locked, no_signal}, 32'd0);

        // Asynchronous reset while locked.
        listen = 1'b1;
        tick(2);
        tone(200, 5);
        tick(1);
        #1;
        check("pre_async_lock", {locked, period}, {1'b1, 20'd200});
        #1;
        reset = 1'b0;
        #1;
        check("async_reset", {period, period_valid, locked, no_signal}, 32'd0);
        tick(2);
        reset = 1'b1;
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
